sonic_echo_emulator: RTL and testbench
======================================

# sonic_echo_emulator

Synthesizable model of the ultrasonic ranging module's responder side: it watches the trigger line driven by the sonic controller and answers with an echo pulse whose width encodes a programmed distance. It replaces the physical sensor in simulation and in hardware-in-loop bring-up on the FPGA. It sits between the controller's Trig output and its Echo input, with distance_cm driven from switches or a testbench.

## Interface
Parameters:
- CLK_PER_US, 100: clk cycles per microsecond (100 MHz system clock).
- MIN_TRIG_US, 10: minimum valid trigger high width, µs.
- BURST_US, 200: delay from accepted trigger fall to echo rise, µs.
- US_PER_CM, 58: echo width per cm, µs.
- MIN_CM, 2: distances below this are clamped up to it.
- MAX_CM, 400: distances above this are out of range.
- TIMEOUT_US, 38000: echo width for an out-of-range distance, µs.
- HOLDOFF_US, 1000: dead time after echo fall, µs.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- trig, in, 1: trigger from controller; asynchronous to clk.
- distance_cm, in, 10: distance to emulate, unsigned cm.
- echo, out, 1: echo pulse to controller; registered.
- busy, out, 1: high in any state other than IDLE.
- trig_err, out, 1: one-cycle pulse when a trigger shorter than MIN_TRIG_US is rejected.

## Operation
- trig passes through a 2-flop synchronizer to give trig_s; an edge register detects rise/fall on trig_s.
- A µs prescaler (0..CLK_PER_US-1) produces us_tick. It restarts at 0 on every state entry, so each state lasts an exact multiple of CLK_PER_US cycles.
- A 16-bit µs counter counts us_ticks and clears on state entry.
- A 16-bit cycle counter measures trig_s high width and saturates at all-ones.
- FSM states and transitions:
  - IDLE: echo=0. Rise of trig_s → ARM, with the cycle counter cleared.
  - ARM: the cycle counter increments while trig_s=1. On fall of trig_s:
    - if count ≥ MIN_TRIG_US·CLK_PER_US, latch distance_cm into dist_q and go to BURST;
    - otherwise pulse trig_err and go to IDLE.
  - BURST: wait BURST_US µs, then go to ECHO.
  - ECHO: echo=1 for W µs, then go to HOLDOFF.
  - HOLDOFF: echo=0 for HOLDOFF_US µs, then go to IDLE.
- Echo width W, in µs:
  - dist_q > MAX_CM: W = TIMEOUT_US.
  - dist_q < MIN_CM: W = MIN_CM·US_PER_CM.
  - otherwise: W = dist_q·US_PER_CM.
  - The product is computed in 16 bits; the maximum is 400·58 = 23200, so there is no overflow.
- distance_cm is sampled only at the accepted trigger fall; later changes do not affect the pulse in flight.
- Trigger edges during BURST, ECHO or HOLDOFF are ignored. A trig still high when HOLDOFF ends is not a rise and is not accepted; a fresh rise is required.
- rst mid-operation: all state returns to reset values immediately, and echo drops asynchronously.

## Timing
- Reset values: echo=0, busy=0, trig_err=0, FSM=IDLE, all counters 0, dist_q=0, synchronizer flops 0.
- trig_s lags raw trig by 2 clk edges. ARM or BURST entry occurs on the edge after the trig_s transition, so 3 edges after the first clk edge that samples the raw change.
- echo rises on the same edge that enters ECHO, exactly BURST_US·CLK_PER_US cycles after BURST entry.
- echo is high for exactly W·CLK_PER_US cycles.
- busy falls exactly HOLDOFF_US·CLK_PER_US cycles after echo falls.
- trig_err is high for one cycle, on the edge that returns the FSM to IDLE from ARM.
- Trigger width boundary: exactly MIN_TRIG_US·CLK_PER_US trig_s-high cycles is accepted; one fewer is rejected.

## Test plan
- Nominal: trig high 1000 cycles, distance_cm=40. Required: echo rises 20000 cycles after BURST entry; echo high exactly 232000 cycles; busy falls 100000 cycles after echo falls.
- Short trigger: trig high 999 cycles. Required: trig_err one-cycle pulse, echo stays 0, busy falls back to 0. Repeating with 1000 cycles is accepted.
- Range limits:
  - distance_cm=401 → echo high 3800000 cycles.
  - distance_cm=0 → echo high 11600 cycles.
  - distance_cm=400 → echo high 2320000 cycles.
- Retrigger and latch: a second trig pulse during ECHO, plus distance_cm changed 40→10 during BURST. Required: a single echo of 232000 cycles, and no second response until after HOLDOFF.
- Reset mid-echo: assert rst 50000 cycles into ECHO. Required: echo=0 and busy=0 immediately. After rst release, a fresh nominal trigger yields a correct 232000-cycle echo.

Source files
------------

// File: rtl/sonic_echo_emulator.sv
// Responder side of an ultrasonic ranging module: watches trig, answers with an
// echo pulse whose width encodes distance_cm, then enforces a dead time.
module sonic_echo_emulator #(
   parameter int CLK_PER_US  = 100,
   parameter int MIN_TRIG_US = 10,
   parameter int BURST_US    = 200,
   parameter int US_PER_CM   = 58,
   parameter int MIN_CM      = 2,
   parameter int MAX_CM      = 400,
   parameter int TIMEOUT_US  = 38000,
   parameter int HOLDOFF_US  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trig,
   input  logic [9:0] distance_cm,
   output logic       echo,
   output logic       busy,
   output logic       trig_err
);

   typedef enum logic [2:0] {IDLE, ARM, BURST, ECHO, HOLDOFF} state_t;

   localparam int            PW         = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);
   localparam logic [15:0]   TRIG_MIN   = 16'(MIN_TRIG_US * CLK_PER_US);
   localparam logic [15:0]   BURST_LAST = 16'(BURST_US - 1);
   localparam logic [15:0]   HOLD_LAST  = 16'(HOLDOFF_US - 1);

   state_t        state, state_next;
   logic          trig_meta, trig_s, trig_s_d;
   logic          rise, fall, us_tick, entering, accept;
   logic [PW-1:0] presc;
   logic [15:0]   us_cnt, cyc_cnt, echo_last;
   logic [9:0]    dist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_meta <= 1'b0;
         trig_s    <= 1'b0;
         trig_s_d  <= 1'b0;
      end else begin
         trig_meta <= trig;
         trig_s    <= trig_meta;
         trig_s_d  <= trig_s;
      end
   end

   assign rise    = trig_s & ~trig_s_d;
   assign fall    = ~trig_s & trig_s_d;
   assign us_tick = (presc == PRESC_LAST);
   assign accept  = (cyc_cnt >= TRIG_MIN);
   assign busy    = (state != IDLE);

   // Echo width in us, less one, so it compares directly against us_cnt.
   always_comb begin
      if (dist_q > 10'(MAX_CM))
         echo_last = 16'(TIMEOUT_US - 1);
      else if (dist_q < 10'(MIN_CM))
         echo_last = 16'(MIN_CM * US_PER_CM - 1);
      else
         echo_last = 16'(dist_q) * 16'(US_PER_CM) - 16'd1;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (rise) state_next = ARM;
         ARM:     if (fall) state_next = accept ? BURST : IDLE;
         BURST:   if (us_tick && us_cnt == BURST_LAST) state_next = ECHO;
         ECHO:    if (us_tick && us_cnt == echo_last) state_next = HOLDOFF;
         HOLDOFF: if (us_tick && us_cnt == HOLD_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign entering = (state_next != state);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         presc    <= '0;
         us_cnt   <= '0;
         cyc_cnt  <= '0;
         dist_q   <= '0;
         echo     <= 1'b0;
         trig_err <= 1'b0;
      end else begin
         state    <= state_next;
         echo     <= (state_next == ECHO);
         trig_err <= (state == ARM) && fall && !accept;
         // Timebase restarts on each state entry so state lengths are exact.
         if (entering || us_tick) presc <= '0;
         else                     presc <= presc + 1'b1;
         if (entering) us_cnt <= '0;
         else          us_cnt <= us_cnt + 16'(us_tick);
         // The rise-detect cycle is itself a trig_s-high cycle, hence the load of 1.
         if (state == IDLE && rise)
            cyc_cnt <= 16'd1;
         else if (state == ARM && trig_s && cyc_cnt != 16'hFFFF)
            cyc_cnt <= cyc_cnt + 16'd1;
         if (state == ARM && fall && accept) dist_q <= distance_cm;
      end
   end

endmodule

// File: tb/tb_sonic_echo_emulator.sv
// Directed bench for sonic_echo_emulator using scaled-down timing parameters
// so every scenario fits in a short run; expected widths are hand-derived.
module tb_sonic_echo_emulator;

   localparam int CLK_PER_US  = 2;
   localparam int MIN_TRIG_US = 5;   // 10-cycle minimum trigger
   localparam int BURST_US    = 20;  // 40 cycles
   localparam int US_PER_CM   = 3;
   localparam int MIN_CM      = 2;
   localparam int MAX_CM      = 40;
   localparam int TIMEOUT_US  = 150; // 300 cycles
   localparam int HOLDOFF_US  = 30;  // 60 cycles
   localparam int LIMIT       = 2000;

   // trig_s lags by 2 edges, state changes on the 3rd, then the burst wait.
   localparam int RISE_CYC = 3 + 40;
   localparam int HOLD_CYC = 60;

   logic       clk, rst, trig, echo, busy, trig_err;
   logic [9:0] distance_cm;
   int         checks, failures;

   sonic_echo_emulator #(
      .CLK_PER_US(CLK_PER_US), .MIN_TRIG_US(MIN_TRIG_US), .BURST_US(BURST_US),
      .US_PER_CM(US_PER_CM), .MIN_CM(MIN_CM), .MAX_CM(MAX_CM),
      .TIMEOUT_US(TIMEOUT_US), .HOLDOFF_US(HOLDOFF_US)
   ) dut (
      .clk(clk), .rst(rst), .trig(trig), .distance_cm(distance_cm),
      .echo(echo), .busy(busy), .trig_err(trig_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Raw trig high for exactly hi posedges; caller is at a negedge.
   task automatic send_trig(input int hi);
      trig = 1'b1;
      repeat (hi) @(negedge clk);
      trig = 1'b0;
   endtask

   task automatic measure(input string tag, input int exp_w);
      int n;
      n = 0;
      while (!echo && n < LIMIT) begin @(negedge clk); n++; end
      check({tag, "_rise"}, n, RISE_CYC);
      n = 0;
      while (echo && n < LIMIT) begin @(negedge clk); n++; end
      check({tag, "_width"}, n, exp_w);
      n = 0;
      while (busy && n < LIMIT) begin @(negedge clk); n++; end
      check({tag, "_holdoff"}, n, HOLD_CYC);
   endtask

   initial begin
      int n, err_cnt, err_at, echo_seen, busy_seen;
      checks = 0; failures = 0;
      rst = 1'b1; trig = 1'b0; distance_cm = 10'd0;
      repeat (3) @(negedge clk);
      check("reset_echo", echo, 0);
      check("reset_busy", busy, 0);
      check("reset_trig_err", trig_err, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Nominal: 10 cm -> 30 us -> 60 cycles
      distance_cm = 10'd10;
      send_trig(20);
      check("nominal_busy", busy, 1);
      measure("nominal", 60);

      // One cycle under the minimum trigger width is rejected
      repeat (5) @(negedge clk);
      send_trig(9);
      check("short_armed", busy, 1);
      err_cnt = 0; err_at = 0; echo_seen = 0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (trig_err) begin err_cnt++; err_at = i; end
         if (echo) echo_seen = 1;
      end
      check("short_err_pulses", err_cnt, 1);
      check("short_err_cycle", err_at, 3);
      check("short_no_echo", echo_seen, 0);
      check("short_idle", busy, 0);

      // Exactly the minimum width is accepted
      send_trig(10);
      measure("min_trig", 60);

      // Range limits
      distance_cm = 10'd41; send_trig(12); measure("over_max", 300);
      distance_cm = 10'd0;  send_trig(12); measure("zero_cm", 12);
      distance_cm = 10'd1;  send_trig(12); measure("one_cm", 12);
      distance_cm = 10'd40; send_trig(12); measure("at_max", 240);

      // Latch and retrigger: distance changes during BURST, trig pulses during ECHO
      distance_cm = 10'd10;
      send_trig(12);
      repeat (10) @(negedge clk);
      distance_cm = 10'd4;
      n = 0;
      while (!echo && n < LIMIT) begin @(negedge clk); n++; end
      check("latch_rise", n, RISE_CYC - 10);
      n = 0;
      while (echo && n < LIMIT) begin
         @(negedge clk); n++;
         if (n == 5)  trig = 1'b1;
         if (n == 20) trig = 1'b0;
      end
      check("latch_width", n, 60);
      n = 0;
      while (busy && n < LIMIT) begin @(negedge clk); n++; end
      check("latch_holdoff", n, HOLD_CYC);
      echo_seen = 0; busy_seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (echo) echo_seen = 1;
         if (busy) busy_seen = 1;
      end
      check("retrig_no_echo", echo_seen, 0);
      check("retrig_no_busy", busy_seen, 0);

      // trig held high across the end of HOLDOFF is not a fresh rise
      distance_cm = 10'd2;
      send_trig(12);
      n = 0;
      while (!echo && n < LIMIT) begin @(negedge clk); n++; end
      while (echo && n < LIMIT) begin @(negedge clk); n++; end
      trig = 1'b1;
      while (busy && n < LIMIT) begin @(negedge clk); n++; end
      busy_seen = 0;
      repeat (30) begin @(negedge clk); if (busy) busy_seen = 1; end
      trig = 1'b0;
      repeat (30) begin @(negedge clk); if (busy) busy_seen = 1; end
      check("held_trig_ignored", busy_seen, 0);

      // Reset mid-echo drops echo and busy asynchronously
      distance_cm = 10'd40;
      send_trig(12);
      n = 0;
      while (!echo && n < LIMIT) begin @(negedge clk); n++; end
      repeat (25) @(negedge clk);
      check("pre_rst_echo", echo, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_echo", echo, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      distance_cm = 10'd10;
      send_trig(12);
      measure("post_rst", 60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
